// File: rtl/btn_event_scheduler.sv
// Four-button debouncer with short/long press classification and a
// round-robin event queue presented on a valid/ready output register.
module btn_event_scheduler #(
  parameter int TICK_DIV   = 50000,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000
) (
  input  logic       i_Clock50MHz,
  input  logic       i_Rst_n,
  input  logic [3:0] i_Btn,
  input  logic       i_Evt_Ready,
  output logic       o_Evt_Valid,
  output logic [1:0] o_Evt_Btn,
  output logic       o_Evt_Long,
  output logic [3:0] o_Btn_State,
  output logic       o_Overrun
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_HELD = 1'b1} state_t;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [3:0]    r_sync1, r_sync2;
  logic [3:0]    w_stable;
  logic [3:0]    w_set_short, w_set_long;
  logic [3:0]    r_pend_short, r_pend_long;
  logic [3:0]    w_clr_short, w_clr_long;
  logic [1:0]    r_rr_ptr;
  logic          w_grant_vld, w_grant_long, w_load, w_take, w_drop;
  logic [1:0]    w_grant_idx;
  logic          r_evt_valid, r_evt_long, r_overrun;
  logic [1:0]    r_evt_btn;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge i_Clock50MHz) begin
    if (!i_Rst_n) begin
      r_tick_cnt <= '0;
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_sync1    <= i_Btn;
      r_sync2    <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic          r_stable;
    logic          r_armed;
    logic [DW-1:0] r_deb_cnt;
    logic [HW-1:0] r_hold;
    state_t        r_state, w_state_next;

    always_ff @(posedge i_Clock50MHz) begin
      if (!i_Rst_n) begin
        r_stable  <= 1'b1;
        r_deb_cnt <= '0;
      end else if (r_sync2[gi] == r_stable) begin
        r_deb_cnt <= '0;
      end else if (w_tick) begin
        if (r_deb_cnt == DW'(DEB_TICKS - 1)) begin
          r_stable  <= r_sync2[gi];
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DW'(1);
        end
      end
    end

    // A button still held across reset must be seen released before it can
    // start a press; the first tick comes after the synchroniser has settled.
    always_ff @(posedge i_Clock50MHz) begin
      if (!i_Rst_n)
        r_armed <= 1'b0;
      else if (w_tick && r_sync2[gi] && r_stable)
        r_armed <= 1'b1;
    end

    always_ff @(posedge i_Clock50MHz) begin
      if (!i_Rst_n) begin
        r_state <= ST_IDLE;
        r_hold  <= '0;
      end else begin
        r_state <= w_state_next;
        if (r_state == ST_IDLE)
          r_hold <= '0;
        else if (w_tick && (r_hold < HW'(LONG_TICKS)))
          r_hold <= r_hold + HW'(1);
      end
    end

    always_comb begin
      w_state_next    = r_state;
      w_set_short[gi] = 1'b0;
      w_set_long[gi]  = 1'b0;
      case (r_state)
        ST_IDLE: if (r_armed && !r_stable) w_state_next = ST_HELD;
        ST_HELD: begin
          if (r_stable) begin
            w_state_next    = ST_IDLE;
            w_set_short[gi] = (r_hold < HW'(LONG_TICKS));
          end else if (w_tick && (r_hold == HW'(LONG_TICKS - 1))) begin
            w_set_long[gi] = 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    assign w_stable[gi] = r_stable;
  end

  // Round-robin search starting one past the last granted button.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = r_rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      if (!w_grant_vld &&
          (r_pend_short[r_rr_ptr + 2'(k)] || r_pend_long[r_rr_ptr + 2'(k)])) begin
        w_grant_vld = 1'b1;
        w_grant_idx = r_rr_ptr + 2'(k);
      end
    end
  end

  assign w_grant_long = r_pend_long[w_grant_idx];
  assign w_load       = !r_evt_valid || i_Evt_Ready;
  assign w_take       = w_load && w_grant_vld;

  always_comb begin
    w_clr_short = '0;
    w_clr_long  = '0;
    if (w_take) begin
      if (w_grant_long) w_clr_long[w_grant_idx]  = 1'b1;
      else              w_clr_short[w_grant_idx] = 1'b1;
    end
  end

  assign w_drop = |(w_set_short & r_pend_short & ~w_clr_short) |
                  |(w_set_long  & r_pend_long  & ~w_clr_long);

  always_ff @(posedge i_Clock50MHz) begin
    if (!i_Rst_n) begin
      r_pend_short <= '0;
      r_pend_long  <= '0;
      r_overrun    <= 1'b0;
      r_evt_valid  <= 1'b0;
      r_evt_btn    <= 2'd0;
      r_evt_long   <= 1'b0;
      r_rr_ptr     <= 2'd3;
    end else begin
      r_pend_short <= w_set_short | (r_pend_short & ~w_clr_short);
      r_pend_long  <= w_set_long  | (r_pend_long  & ~w_clr_long);
      r_overrun    <= w_drop;
      if (w_load) begin
        r_evt_valid <= w_grant_vld;
        if (w_grant_vld) begin
          r_evt_btn  <= w_grant_idx;
          r_evt_long <= w_grant_long;
          r_rr_ptr   <= w_grant_idx;
        end
      end
    end
  end

  assign o_Evt_Valid = r_evt_valid;
  assign o_Evt_Btn   = r_evt_btn;
  assign o_Evt_Long  = r_evt_long;
  assign o_Btn_State = w_stable;
  assign o_Overrun   = r_overrun;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed bench for btn_event_scheduler with TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10.
module tb_btn_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'hF;
  logic       ready = 1'b0;
  logic       evt_valid, evt_long, overrun;
  logic [1:0] evt_btn;
  logic [3:0] btn_state;

  int n_tests = 0;
  int n_fail  = 0;
  int ev_cnt  = 0;
  int ov_cnt  = 0;
  int low_cnt = 0;
  logic [2:0] ev_log [0:63];

  always #5 clk = ~clk;

  btn_event_scheduler #(.TICK_DIV(4), .DEB_TICKS(3), .LONG_TICKS(10)) dut (
    .i_Clock50MHz (clk),
    .i_Rst_n      (rst_n),
    .i_Btn        (btn),
    .i_Evt_Ready  (ready),
    .o_Evt_Valid  (evt_valid),
    .o_Evt_Btn    (evt_btn),
    .o_Evt_Long   (evt_long),
    .o_Btn_State  (btn_state),
    .o_Overrun    (overrun)
  );

  // Event log entry is {long, btn}.
  always @(posedge clk) begin
    if (rst_n && evt_valid && ready) begin
      ev_log[ev_cnt[5:0]] <= {evt_long, evt_btn};
      ev_cnt <= ev_cnt + 1;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (btn_state != 4'hF) low_cnt <= low_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int n);
    btn = btn & ~mask;
    cycles(n);
    btn = btn | mask;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(12);
  endtask

  initial begin
    int base, obase, lbase, lat;
    logic seen;

    // Reset values
    cycles(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_btn",   32'(evt_btn),   32'd0);
    chk("rst_long",  32'(evt_long),  32'd0);
    chk("rst_state", 32'(btn_state), 32'hF);
    chk("rst_ovr",   32'(overrun),   32'd0);
    rst_n = 1'b1;
    cycles(12);

    // Bouncy short glitch on button 1 is rejected
    ready = 1'b1;
    base = ev_cnt; lbase = low_cnt;
    press(4'b0010, 5);
    cycles(1);
    press(4'b0010, 5);
    cycles(25);
    chk("bounce_state_low_cycles", 32'(low_cnt - lbase), 32'd0);
    chk("bounce_events", 32'(ev_cnt - base), 32'd0);

    // Short press on button 2
    base = ev_cnt;
    btn[2] = 1'b0;
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!seen && !btn_state[2]) begin seen = 1'b1; lat = i; end
    end
    chk("deb_seen", 32'(seen), 32'd1);
    chk("deb_latency_in_range", 32'((lat >= 9) && (lat <= 16)), 32'd1);
    btn[2] = 1'b1;
    cycles(30);
    chk("short2_count", 32'(ev_cnt - base), 32'd1);
    chk("short2_event", 32'(ev_log[base[5:0]]), 32'b0_10);
    chk("short2_state_after", 32'(btn_state), 32'hF);

    // Long press on button 0, event while still held, nothing on release
    do_reset();
    base = ev_cnt;
    btn[0] = 1'b0;
    cycles(64);
    chk("long0_count_held", 32'(ev_cnt - base), 32'd1);
    chk("long0_event", 32'(ev_log[base[5:0]]), 32'b1_00);
    btn[0] = 1'b1;
    cycles(30);
    chk("long0_count_released", 32'(ev_cnt - base), 32'd1);

    // Simultaneous short presses on 0,1,3 with a stalled consumer
    do_reset();
    ready = 1'b0;
    base = ev_cnt;
    press(4'b1011, 20);
    cycles(30);
    chk("multi_stall_valid", 32'(evt_valid), 32'd1);
    chk("multi_stall_fields", 32'({evt_long, evt_btn}), 32'b0_00);
    cycles(10);
    chk("multi_stall_valid_hold", 32'(evt_valid), 32'd1);
    chk("multi_stall_fields_hold", 32'({evt_long, evt_btn}), 32'b0_00);
    ready = 1'b1;
    cycles(10);
    chk("multi_count", 32'(ev_cnt - base), 32'd3);
    chk("multi_ev0", 32'(ev_log[6'(base)]), 32'b0_00);
    chk("multi_ev1", 32'(ev_log[6'(base + 1)]), 32'b0_01);
    chk("multi_ev2", 32'(ev_log[6'(base + 2)]), 32'b0_11);
    chk("multi_valid_idle", 32'(evt_valid), 32'd0);

    // Overrun: output held by button 0, two presses on button 3
    do_reset();
    ready = 1'b0;
    base = ev_cnt; obase = ov_cnt;
    press(4'b0001, 20);
    cycles(25);
    press(4'b1000, 20);
    cycles(25);
    chk("ovr_none_yet", 32'(ov_cnt - obase), 32'd0);
    press(4'b1000, 20);
    cycles(25);
    chk("ovr_pulses", 32'(ov_cnt - obase), 32'd1);
    chk("ovr_head_fields", 32'({evt_valid, evt_long, evt_btn}), 32'b1_0_00);
    ready = 1'b1;
    cycles(10);
    chk("ovr_count", 32'(ev_cnt - base), 32'd2);
    chk("ovr_ev0", 32'(ev_log[6'(base)]), 32'b0_00);
    chk("ovr_ev1", 32'(ev_log[6'(base + 1)]), 32'b0_11);

    // Reset mid-press while an event is waiting
    do_reset();
    ready = 1'b0;
    obase = ov_cnt;
    press(4'b0010, 20);
    cycles(25);
    chk("midrst_pre_valid", 32'(evt_valid), 32'd1);
    btn[2] = 1'b0;
    cycles(20);
    chk("midrst_pre_state", 32'(btn_state[2]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_valid", 32'(evt_valid), 32'd0);
    chk("midrst_btn",   32'(evt_btn),   32'd0);
    chk("midrst_long",  32'(evt_long),  32'd0);
    chk("midrst_state", 32'(btn_state), 32'hF);
    chk("midrst_ovr",   32'(overrun),   32'd0);
    base = ev_cnt;
    ready = 1'b1;
    cycles(20);
    btn[2] = 1'b1;
    cycles(40);
    chk("midrst_no_event", 32'(ev_cnt - base), 32'd0);
    chk("midrst_no_ovr", 32'(ov_cnt - obase), 32'd0);

    // Fresh press after reset works again
    base = ev_cnt;
    press(4'b0100, 20);
    cycles(30);
    chk("fresh_count", 32'(ev_cnt - base), 32'd1);
    chk("fresh_event", 32'(ev_log[base[5:0]]), 32'b0_10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
